// File: rtl/addr_map_table.sv
// addr_map_table: programmable two-stage SNES address translator.
// A table of NREGIONS match windows (MATCH/MMASK/BASE/SIZE/ATTR) maps SNES_ADDR
// to ROM_ADDR plus ROM/SAVERAM/WRITABLE flags. The MCU writes a shadow table and
// commits it atomically once no lookup is in flight.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   SNES_ADDR, addr_valid     lookup request, one per cycle
//   cfg_wr/idx/field/data     shadow table field write
//   cfg_commit, cfg_busy      shadow->active commit request / commit pending
//   ROM_ADDR, IS_ROM, IS_SAVERAM, IS_WRITABLE, hit_idx, miss, out_valid
//                             registered lookup result, two cycles after request
module addr_map_table #(
    parameter int unsigned NREGIONS = 8,
    parameter int unsigned IDXW     = 3,
    parameter int unsigned AW       = 24
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   SNES_ADDR,
    input  logic            addr_valid,
    input  logic            cfg_wr,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [2:0]      cfg_field,
    input  logic [AW-1:0]   cfg_data,
    input  logic            cfg_commit,
    output logic            cfg_busy,
    output logic [AW-1:0]   ROM_ADDR,
    output logic            IS_ROM,
    output logic            IS_SAVERAM,
    output logic            IS_WRITABLE,
    output logic [IDXW-1:0] hit_idx,
    output logic            miss,
    output logic            out_valid
);

    localparam int unsigned ATTRW      = 5;
    localparam int unsigned A_EN       = 0;
    localparam int unsigned A_LOROM    = 1;
    localparam int unsigned A_ROM      = 2;
    localparam int unsigned A_SAVERAM  = 3;
    localparam int unsigned A_WRITABLE = 4;

    typedef struct packed {
        logic [AW-1:0]    match;
        logic [AW-1:0]    mmask;
        logic [AW-1:0]    base;
        logic [AW-1:0]    size;
        logic [ATTRW-1:0] attr;
    } region_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_APPLY} state_t;

    state_t  state_q, state_d;
    logic    cfg_busy_q, cfg_busy_d;
    region_t shadow_q [NREGIONS];
    region_t shadow_d [NREGIONS];
    region_t active_q [NREGIONS];
    region_t active_d [NREGIONS];

    logic                v1_q, v1_d;
    logic [AW-1:0]       addr1_q, addr1_d;
    logic [AW-1:0]       comp1_q, comp1_d;
    logic [NREGIONS-1:0] hit1_q, hit1_d;

    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            is_rom_q, is_rom_d;
    logic            is_saveram_q, is_saveram_d;
    logic            is_writable_q, is_writable_d;
    logic [IDXW-1:0] hit_idx_q, hit_idx_d;
    logic            miss_q, miss_d;

    logic [AW-1:0]   match_v [NREGIONS];
    logic [AW-1:0]   mmask_v [NREGIONS];
    logic            en_v    [NREGIONS];
    logic [IDXW-1:0] win;
    logic            found;
    logic [AW-1:0]   off;

    // Shadow writes and commit sequencing
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_wr && ({1'b0, cfg_idx} < (IDXW+1)'(NREGIONS))) begin
                    case (cfg_field)
                        3'd0:    shadow_d[cfg_idx].match = cfg_data;
                        3'd1:    shadow_d[cfg_idx].mmask = cfg_data;
                        3'd2:    shadow_d[cfg_idx].base  = cfg_data;
                        3'd3:    shadow_d[cfg_idx].size  = cfg_data;
                        3'd4:    shadow_d[cfg_idx].attr  = cfg_data[ATTRW-1:0];
                        default: ;
                    endcase
                end
                if (cfg_commit) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!v1_q && !out_valid_q && !addr_valid) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                active_d = shadow_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        cfg_busy_d = (state_d != ST_IDLE);
    end

    // A lookup accepted on the APPLY edge must already see the new table,
    // because its stage 2 reads the freshly copied active entries.
    always_comb begin
        for (int i = 0; i < int'(NREGIONS); i++) begin
            match_v[i] = (state_q == ST_APPLY) ? shadow_q[i].match       : active_q[i].match;
            mmask_v[i] = (state_q == ST_APPLY) ? shadow_q[i].mmask       : active_q[i].mmask;
            en_v[i]    = (state_q == ST_APPLY) ? shadow_q[i].attr[A_EN]  : active_q[i].attr[A_EN];
        end
    end

    // Stage 1: capture address, LoROM-compacted offset and per-region hits
    always_comb begin
        v1_d    = addr_valid;
        addr1_d = addr1_q;
        comp1_d = comp1_q;
        hit1_d  = hit1_q;
        if (addr_valid) begin
            addr1_d = SNES_ADDR;
            comp1_d = {1'b0, SNES_ADDR[AW-1:16], SNES_ADDR[14:0]};
            for (int i = 0; i < int'(NREGIONS); i++) begin
                hit1_d[i] = en_v[i] && ((SNES_ADDR & mmask_v[i]) == (match_v[i] & mmask_v[i]));
            end
        end
    end

    // Stage 2: lowest-index winner, offset mask and base add (carry dropped)
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = int'(NREGIONS) - 1; i >= 0; i--) begin
            if (hit1_q[i]) begin
                win   = IDXW'(i);
                found = 1'b1;
            end
        end
        off = active_q[win].attr[A_LOROM] ? comp1_q : addr1_q;

        out_valid_d   = v1_q;
        rom_addr_d    = rom_addr_q;
        is_rom_d      = is_rom_q;
        is_saveram_d  = is_saveram_q;
        is_writable_d = is_writable_q;
        hit_idx_d     = hit_idx_q;
        miss_d        = miss_q;
        if (v1_q) begin
            if (found) begin
                rom_addr_d    = active_q[win].base + (off & active_q[win].size);
                is_rom_d      = active_q[win].attr[A_ROM];
                is_saveram_d  = active_q[win].attr[A_SAVERAM];
                is_writable_d = active_q[win].attr[A_WRITABLE] | active_q[win].attr[A_SAVERAM];
                hit_idx_d     = win;
                miss_d        = 1'b0;
            end else begin
                rom_addr_d    = '0;
                is_rom_d      = 1'b0;
                is_saveram_d  = 1'b0;
                is_writable_d = 1'b0;
                hit_idx_d     = '0;
                miss_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cfg_busy_q <= 1'b0;
            for (int i = 0; i < int'(NREGIONS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            v1_q          <= 1'b0;
            addr1_q       <= '0;
            comp1_q       <= '0;
            hit1_q        <= '0;
            out_valid_q   <= 1'b0;
            rom_addr_q    <= '0;
            is_rom_q      <= 1'b0;
            is_saveram_q  <= 1'b0;
            is_writable_q <= 1'b0;
            hit_idx_q     <= '0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_busy_q    <= cfg_busy_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            v1_q          <= v1_d;
            addr1_q       <= addr1_d;
            comp1_q       <= comp1_d;
            hit1_q        <= hit1_d;
            out_valid_q   <= out_valid_d;
            rom_addr_q    <= rom_addr_d;
            is_rom_q      <= is_rom_d;
            is_saveram_q  <= is_saveram_d;
            is_writable_q <= is_writable_d;
            hit_idx_q     <= hit_idx_d;
            miss_q        <= miss_d;
        end
    end

    assign cfg_busy    = cfg_busy_q;
    assign ROM_ADDR    = rom_addr_q;
    assign IS_ROM      = is_rom_q;
    assign IS_SAVERAM  = is_saveram_q;
    assign IS_WRITABLE = is_writable_q;
    assign hit_idx     = hit_idx_q;
    assign miss        = miss_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_addr_map_table.sv
// tb_addr_map_table: directed bench for addr_map_table. The driver queues the
// hand-computed result of each lookup; a negedge monitor pops and compares
// whenever out_valid is high.
module tb_addr_map_table;

    localparam int unsigned AW   = 24;
    localparam int unsigned IDXW = 3;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            rom;
        logic            sav;
        logic            wr;
        logic [IDXW-1:0] idx;
        logic            miss;
    } res_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [AW-1:0]   SNES_ADDR = '0;
    logic            addr_valid = 1'b0;
    logic            cfg_wr = 1'b0;
    logic [IDXW-1:0] cfg_idx = '0;
    logic [2:0]      cfg_field = '0;
    logic [AW-1:0]   cfg_data = '0;
    logic            cfg_commit = 1'b0;
    logic            cfg_busy;
    logic [AW-1:0]   ROM_ADDR;
    logic            IS_ROM, IS_SAVERAM, IS_WRITABLE;
    logic [IDXW-1:0] hit_idx;
    logic            miss;
    logic            out_valid;

    res_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    addr_map_table #(.NREGIONS(8), .IDXW(IDXW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR), .addr_valid(addr_valid),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .ROM_ADDR(ROM_ADDR),
        .IS_ROM(IS_ROM), .IS_SAVERAM(IS_SAVERAM), .IS_WRITABLE(IS_WRITABLE),
        .hit_idx(hit_idx), .miss(miss), .out_valid(out_valid)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Monitor: compare every presented result against the oldest expectation
    always @(negedge CLK) begin : monitor
        res_t got, exp;
        if (!RST && out_valid) begin
            got = {ROM_ADDR, IS_ROM, IS_SAVERAM, IS_WRITABLE, hit_idx, miss};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got addr=%h rom=%b sav=%b wr=%b idx=%0d miss=%b, required none",
                         got.addr, got.rom, got.sav, got.wr, got.idx, got.miss);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL lookup_result: got addr=%h rom=%b sav=%b wr=%b idx=%0d miss=%b, required addr=%h rom=%b sav=%b wr=%b idx=%0d miss=%b",
                             got.addr, got.rom, got.sav, got.wr, got.idx, got.miss,
                             exp.addr, exp.rom, exp.sav, exp.wr, exp.idx, exp.miss);
                end
            end
        end
    end

    function automatic res_t mk(input logic [AW-1:0] a, input logic r, input logic s,
                                input logic w, input logic [IDXW-1:0] i, input logic m);
        res_t t;
        t.addr = a; t.rom = r; t.sav = s; t.wr = w; t.idx = i; t.miss = m;
        return t;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [IDXW-1:0] idx, input logic [2:0] field, input logic [AW-1:0] data);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_field = field; cfg_data = data;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic write_region(input logic [IDXW-1:0] idx, input logic [AW-1:0] m, input logic [AW-1:0] mm,
                                input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW-1:0] a);
        cfg_write(idx, 3'd0, m);
        cfg_write(idx, 3'd1, mm);
        cfg_write(idx, 3'd2, b);
        cfg_write(idx, 3'd3, s);
        cfg_write(idx, 3'd4, a);
    endtask

    task automatic commit();
        int n;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("busy_after_commit", 32'(cfg_busy), 32'd1);
        n = 0;
        while (cfg_busy && n < 20) begin
            tick();
            n++;
        end
        check("commit_done", 32'(cfg_busy), 32'd0);
    endtask

    task automatic lookup(input logic [AW-1:0] a);
        SNES_ADDR = a; addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
    endtask

    task automatic lookup_exp(input logic [AW-1:0] a, input res_t e);
        exp_q.push_back(e);
        lookup(a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // 1. reset state and first-lookup latency on an empty table
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_rom_addr", 32'(ROM_ADDR), 32'd0);
        check("rst_flags", {28'd0, IS_ROM, IS_SAVERAM, IS_WRITABLE, miss}, 32'd0);
        exp_q.push_back(mk(24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
        lookup(24'h008000);
        check("latency_edge1", 32'(out_valid), 32'd0);
        tick();
        check("latency_edge2", 32'(out_valid), 32'd1);
        drain();

        // 2. LoROM window (bit15 set, bit22 clear): 0x018123 compacts to 0x008123
        write_region(3'd0, 24'h008000, 24'h408000, 24'h000000, 24'h3FFFFF, 24'h000007);
        commit();
        lookup_exp(24'h018123, mk(24'h008123, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
        drain();

        // 3. SRAM window and catch-all; shadow writes invisible until commit
        write_region(3'd1, 24'h200000, 24'h60E000, 24'h600000, 24'h001FFF, 24'h000009);
        write_region(3'd2, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000005);
        lookup_exp(24'h201ABC, mk(24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
        drain();
        commit();
        lookup_exp(24'h201ABC, mk(24'h601ABC, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0));
        lookup_exp(24'h7E0000, mk(24'h000000, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0));
        lookup_exp(24'h008000, mk(24'h000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
        drain();

        // 4. commit requested mid-stream waits for the pipeline to empty
        cfg_write(3'd0, 3'd2, 24'h100000);
        for (int k = 0; k < 10; k++) begin
            SNES_ADDR  = {8'(k), 16'h8000};
            addr_valid = 1'b1;
            cfg_commit = (k == 3);
            cfg_wr     = (k == 5);
            cfg_idx    = 3'd0; cfg_field = 3'd2; cfg_data = 24'hABCDEF;
            exp_q.push_back(mk(24'(k) << 15, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
            tick();
            cfg_commit = 1'b0;
            cfg_wr     = 1'b0;
            if (k >= 3) check("busy_during_stream", 32'(cfg_busy), 32'd1);
        end
        addr_valid = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check("busy_after_stream", 32'(cfg_busy), (t < 4) ? 32'd1 : 32'd0);
        end
        lookup_exp(24'h008000, mk(24'h100000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
        drain();

        // 5. base+offset wraps modulo 2^24; field 7 writes are ignored
        write_region(3'd0, 24'h000000, 24'h000000, 24'hFFFF00, 24'h0000FF, 24'h000001);
        commit();
        lookup_exp(24'h0001F0, mk(24'hFFFFF0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
        drain();
        tick();
        check("hold_rom_addr", 32'(ROM_ADDR), 32'h00FFFFF0);
        cfg_write(3'd0, 3'd2, 24'hFFFFF0);
        cfg_write(3'd0, 3'd7, 24'hFFFFFF);
        commit();
        lookup_exp(24'h000020, mk(24'h000010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
        drain();
        check("wrap_no_x", 32'($isunknown(ROM_ADDR)), 32'd0);

        // 6. reset with a commit pending and two lookups in flight
        cfg_commit = 1'b1; SNES_ADDR = 24'h008000; addr_valid = 1'b1;
        tick();
        cfg_commit = 1'b0; SNES_ADDR = 24'h000100;
        tick();
        addr_valid = 1'b0;
        check("busy_before_reset", 32'(cfg_busy), 32'd1);
        RST = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(cfg_busy), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        lookup_exp(24'h008000, mk(24'h000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
        drain();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
